// File: rtl/potential_decay_array.sv
// potential_decay_array
//   Holds single-precision membrane potentials for NEURONS neurons, each with
//   its own power-of-two decay shift. A rising edge on `clear` starts a sweep
//   that visits one neuron per cycle: the potential is decayed by subtracting
//   the shift from its exponent, compared with `threshold`, and either stored
//   back or replaced by `reset_potential` with an address-tagged spike.
//
// Ports
//   CLK, RESET            clock (rising edge), async active-high reset
//   clear                 timestep marker; rising edge starts a sweep
//   init_*                write potential + shift (IDLE only, wins over update)
//   update_*              overwrite potential (IDLE only)
//   wr_ready              writes accepted this cycle (= ~busy)
//   threshold             positive float firing threshold
//   reset_potential       value stored into a neuron that fires
//   rd_addr/rd_potential  combinational debug read
//   busy                  sweep in progress (SCAN or DONE)
//   spike_valid/addr      registered one-cycle spike strobe
//   done                  one-cycle end-of-sweep pulse
module potential_decay_array #(
    parameter int NEURONS = 16,
    parameter int ADDR_W  = 4,
    parameter int SHIFT_W = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               clear,
    input  logic               init_valid,
    input  logic [ADDR_W-1:0]  init_addr,
    input  logic [31:0]        init_potential,
    input  logic [SHIFT_W-1:0] init_shift,
    input  logic               update_valid,
    input  logic [ADDR_W-1:0]  update_addr,
    input  logic [31:0]        update_potential,
    output logic               wr_ready,
    input  logic [31:0]        threshold,
    input  logic [31:0]        reset_potential,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [31:0]        rd_potential,
    output logic               busy,
    output logic               spike_valid,
    output logic [ADDR_W-1:0]  spike_addr,
    output logic               done
);

    localparam int IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NEURONS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_nxt;
    logic               clear_q;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        pot [NEURONS];
    logic [SHIFT_W-1:0] shf [NEURONS];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(NEURONS);
    endfunction

    // Only the magnitude bits of the threshold take part in the compare.
    logic unused_thr_sign;
    assign unused_thr_sign = threshold[31];

    // ---------------- decay + fire for the neuron under the sweep index
    logic [31:0] cur_p, decayed;
    logic [7:0]  cur_e, sh8;
    logic        is_nan, fire;

    assign cur_p = pot[idx];
    assign cur_e = cur_p[30:23];
    assign sh8   = 8'(shf[idx]);

    always_comb begin
        decayed = cur_p;
        if (cur_e == 8'hFF)
            decayed = cur_p;                        // Inf/NaN pass through
        else if (cur_e == 8'h00)
            decayed = 32'h0;                        // zero/denormal -> +0
        else if (sh8 == 8'h00)
            decayed = cur_p;
        else if (cur_e <= sh8)
            decayed = 32'h0;                        // would leave normal range
        else
            decayed = {cur_p[31], cur_e - sh8, cur_p[22:0]};
    end

    assign is_nan = (decayed[30:23] == 8'hFF) && (decayed[22:0] != 23'h0);
    // Unsigned compare of the low 31 bits orders positive floats correctly.
    assign fire   = !decayed[31] && !is_nan && (decayed[30:0] >= threshold[30:0]);

    // ---------------- FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear && !clear_q) state_nxt = SCAN;
            SCAN:    if (idx == LAST)       state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign wr_ready = !busy;
    assign done     = (state == DONE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            clear_q     <= 1'b0;
            idx         <= '0;
            spike_valid <= 1'b0;
            spike_addr  <= '0;
            for (int i = 0; i < NEURONS; i++) begin
                pot[i] <= 32'h0;
                shf[i] <= '0;
            end
        end else begin
            state       <= state_nxt;
            clear_q     <= clear;               // edge detector runs in every state
            spike_valid <= 1'b0;
            if (state == SCAN) begin
                pot[idx]    <= fire ? reset_potential : decayed;
                spike_valid <= fire;
                spike_addr  <= ADDR_W'(idx);
                idx         <= (idx == LAST) ? '0 : idx + 1'b1;
            end else if (state == IDLE) begin
                // init takes priority; a simultaneous update is dropped
                if (init_valid) begin
                    if (in_range(init_addr)) begin
                        pot[IDX_W'(init_addr)] <= init_potential;
                        shf[IDX_W'(init_addr)] <= init_shift;
                    end
                end else if (update_valid && in_range(update_addr)) begin
                    pot[IDX_W'(update_addr)] <= update_potential;
                end
            end
        end
    end

    // ---------------- debug read
    always_comb begin
        rd_potential = 32'h0;
        if (in_range(rd_addr)) rd_potential = pot[IDX_W'(rd_addr)];
    end

endmodule

// File: tb/tb_potential_decay_array.sv
module tb_potential_decay_array;

    localparam int N       = 4;
    localparam int ADDR_W  = 4;
    localparam int SHIFT_W = 3;
    localparam int WIN     = 3*N + 4;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               clear = 1'b0;
    logic               init_valid = 1'b0;
    logic [ADDR_W-1:0]  init_addr = '0;
    logic [31:0]        init_potential = '0;
    logic [SHIFT_W-1:0] init_shift = '0;
    logic               update_valid = 1'b0;
    logic [ADDR_W-1:0]  update_addr = '0;
    logic [31:0]        update_potential = '0;
    logic               wr_ready;
    logic [31:0]        threshold = 32'h42C80000;
    logic [31:0]        reset_potential = 32'h0;
    logic [ADDR_W-1:0]  rd_addr = '0;
    logic [31:0]        rd_potential;
    logic               busy, spike_valid, done;
    logic [ADDR_W-1:0]  spike_addr;

    potential_decay_array #(.NEURONS(N), .ADDR_W(ADDR_W), .SHIFT_W(SHIFT_W)) dut (
        .CLK(CLK), .RESET(RESET), .clear(clear),
        .init_valid(init_valid), .init_addr(init_addr),
        .init_potential(init_potential), .init_shift(init_shift),
        .update_valid(update_valid), .update_addr(update_addr),
        .update_potential(update_potential), .wr_ready(wr_ready),
        .threshold(threshold), .reset_potential(reset_potential),
        .rd_addr(rd_addr), .rd_potential(rd_potential), .busy(busy),
        .spike_valid(spike_valid), .spike_addr(spike_addr), .done(done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // sweep observations
    int spk_cnt, done_cnt, done_cyc, busy_cnt;
    int spk_cyc [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_init(input int a, input logic [31:0] p, input int s);
        init_valid = 1'b1; init_addr = ADDR_W'(a);
        init_potential = p; init_shift = SHIFT_W'(s);
        step();
        init_valid = 1'b0;
    endtask

    task automatic do_update(input int a, input logic [31:0] p);
        update_valid = 1'b1; update_addr = ADDR_W'(a); update_potential = p;
        step();
        update_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
        rd_addr = ADDR_W'(a);
        #1;
        chk(tag, rd_potential, exp);
    endtask

    // Raise clear (edge t samples it), then observe cycles t+1..t+WIN.
    // clear stays high for clr_len cycles in total; glitch_c re-raises it
    // for one cycle to create a second rising edge. busy_wr tries a write
    // while the sweep is running.
    task automatic run_sweep(input int clr_len, input int glitch_c, input bit busy_wr);
        spk_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        foreach (spk_cyc[i]) spk_cyc[i] = -1;
        clear = 1'b1;
        for (int c = 1; c <= WIN; c++) begin
            step();
            if (spike_valid) begin
                spk_cnt++;
                spk_cyc[spike_addr] = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy) busy_cnt++;
            if (c == N + 2) chk("wr_ready_back", 32'(wr_ready), 32'd1);
            if (busy_wr && c == 2) begin
                chk("wr_ready_busy", 32'(wr_ready), 32'd0);
                update_valid = 1'b1; update_addr = 1; update_potential = 32'h40E00000;
            end else begin
                update_valid = 1'b0;
            end
            clear = (c < clr_len) || (c == glitch_c);
        end
        clear = 1'b0;
        update_valid = 1'b0;
    endtask

    initial begin
        // ---- reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_spike_valid", 32'(spike_valid), 32'd0);
        chk("rst_spike_addr", 32'(spike_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        rd_chk("rst_pot0", 0, 32'h0);
        RESET = 1'b0;
        step();

        // ---- reset mid-sweep
        do_init(3, 32'h41200000, 0);
        rd_chk("init_visible", 3, 32'h41200000);
        clear = 1'b1;
        step();                     // cycle t+1
        clear = 1'b0;
        step();                     // cycle t+2
        chk("mid_busy_before", 32'(busy), 32'd1);
        RESET = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_spike", 32'(spike_valid), 32'd0);
        rd_chk("mid_pot3", 3, 32'h0);
        #1 RESET = 1'b0;
        step();
        run_sweep(1, 0, 1'b0);
        chk("mid_next_done_cnt", 32'(done_cnt), 32'd1);
        chk("mid_next_busy_cnt", 32'(busy_cnt), 32'(N + 1));
        chk("mid_next_spikes", 32'(spk_cnt), 32'd0);

        // ---- basic decay
        threshold = 32'h42C80000;
        do_init(0, 32'h41200000, 1);
        run_sweep(1, 0, 1'b0);
        rd_chk("decay_pot0", 0, 32'h40A00000);
        chk("decay_spikes", 32'(spk_cnt), 32'd0);
        chk("decay_done_cyc", 32'(done_cyc), 32'(N + 1));
        chk("decay_done_cnt", 32'(done_cnt), 32'd1);

        // ---- fire / reset
        threshold = 32'h40800000; reset_potential = 32'h0;
        do_init(2, 32'h41000000, 1);
        run_sweep(1, 0, 1'b0);
        chk("fire_cnt", 32'(spk_cnt), 32'd1);
        chk("fire_cyc2", 32'(spk_cyc[2]), 32'd4);
        rd_chk("fire_pot2", 2, 32'h0);
        rd_chk("fire_pot0", 0, 32'h40200000);

        // ---- boundaries
        reset_potential = 32'h3F000000;
        do_init(0, 32'hC1200000, 2);
        do_init(1, 32'h00800000, 3);
        do_init(2, 32'h02000000, 3);
        do_init(3, 32'h7F800000, 1);
        run_sweep(1, 0, 1'b0);
        rd_chk("bnd_neg", 0, 32'hC0200000);
        rd_chk("bnd_underflow", 1, 32'h0);
        rd_chk("bnd_exp_min", 2, 32'h00800000);
        rd_chk("bnd_inf_reset", 3, 32'h3F000000);
        chk("bnd_spike_cnt", 32'(spk_cnt), 32'd1);
        chk("bnd_inf_spike_cyc", 32'(spk_cyc[3]), 32'(N + 1));
        chk("bnd_done_cyc", 32'(done_cyc), 32'(N + 1));

        // ---- write arbitration
        threshold = 32'h40000000; reset_potential = 32'h12345678;
        init_valid = 1'b1; init_addr = 1; init_potential = 32'h3F800000; init_shift = 0;
        update_valid = 1'b1; update_addr = 1; update_potential = 32'h40000000;
        step();
        init_valid = 1'b0; update_valid = 1'b0;
        rd_chk("arb_init_wins", 1, 32'h3F800000);
        do_update(5, 32'h41100000);
        rd_chk("arb_oob_ignored", 1, 32'h3F800000);
        do_update(0, 32'h40E00000);
        rd_chk("arb_update", 0, 32'h40E00000);
        do_init(0, 32'h7FC00000, 2);
        do_init(2, 32'h40400000, 0);
        run_sweep(1, 0, 1'b1);
        rd_chk("arb_nan", 0, 32'h7FC00000);
        rd_chk("arb_busy_drop", 1, 32'h3F800000);
        rd_chk("arb_shift0_fire", 2, 32'h12345678);
        rd_chk("arb_pot3", 3, 32'h3E800000);
        chk("arb_spike_cnt", 32'(spk_cnt), 32'd1);
        chk("arb_spike_cyc2", 32'(spk_cyc[2]), 32'd4);

        // ---- clear held high for 3N cycles
        run_sweep(3*N, 0, 1'b0);
        chk("hold_done_cnt", 32'(done_cnt), 32'd1);
        chk("hold_busy_cnt", 32'(busy_cnt), 32'(N + 1));
        chk("hold_spikes", 32'(spk_cnt), 32'd0);

        // ---- second rising edge during SCAN
        run_sweep(1, 2, 1'b0);
        chk("glitch_done_cnt", 32'(done_cnt), 32'd1);
        chk("glitch_busy_cnt", 32'(busy_cnt), 32'(N + 1));
        chk("glitch_done_cyc", 32'(done_cyc), 32'(N + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/potential_decay_array.md
# potential_decay_array

Multi-neuron, clocked successor to the single-neuron potential decay unit. Holds IEEE-754 single-precision membrane potentials for `NEURONS` neurons, each with its own power-of-two decay shift. On every timestep boundary it sweeps all neurons, one per cycle: it applies exponent-subtract decay, compares the result against a firing threshold, and emits address-tagged spikes with a potential reset. It sits between the potential adder (writes) and the spike router (spike outputs).

## Interface
- `NEURONS`, 16, number of neurons held (≥2)
- `ADDR_W`, 4, neuron address width, ≥ clog2(NEURONS)
- `SHIFT_W`, 3, width of per-neuron decay shift (divide by 2^shift)
- `CLK` input 1 — single clock, rising edge
- `RESET` input 1 — asynchronous, active-high reset
- `clear` input 1 — timestep marker; a rising edge starts a sweep
- `init_valid` input 1 — write potential and shift for `init_addr`
- `init_addr` input ADDR_W — target neuron
- `init_potential` input 32 — initial float potential
- `init_shift` input SHIFT_W — decay shift for that neuron
- `update_valid` input 1 — overwrite potential from the potential adder
- `update_addr` input ADDR_W — target neuron
- `update_potential` input 32 — new float potential
- `wr_ready` output 1 — writes accepted this cycle (= not busy)
- `threshold` input 32 — firing threshold, positive float, held stable during a sweep
- `reset_potential` input 32 — value written to a neuron that fires
- `rd_addr` input ADDR_W — debug read address
- `rd_potential` output 32 — combinational read of the stored potential
- `busy` output 1 — sweep in progress
- `spike_valid` output 1 — one-cycle spike strobe
- `spike_addr` output ADDR_W — firing neuron
- `done` output 1 — one-cycle end-of-sweep pulse

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE→SCAN on a detected rising edge of `clear` (`clear` high, registered previous value low).
  - SCAN→DONE after index NEURONS-1 is processed.
  - DONE→IDLE unconditionally.
- The edge detector runs in every state. `clear` edges in SCAN or DONE are ignored and are not queued.
- Writes are accepted only in IDLE. `init_valid`/`update_valid` while busy are dropped. When both are valid on the same cycle, init wins and the update is dropped. Out-of-range addresses (≥ NEURONS) are ignored.
- Decay of potential p with shift s. Fields: sign S, exponent E, mantissa M.
  - E==255 (Inf/NaN): unchanged.
  - E==0 (zero/denormal): result +0 (0x00000000).
  - s==0: unchanged.
  - E ≤ s: underflow flushes to +0.
  - Otherwise: {S, E−s, M}.
- Fire test on the decayed value d. Fire when all of the following hold:
  - S==0
  - d is not NaN
  - d[30:0] ≥ threshold[30:0] (unsigned magnitude compare, valid for positive floats)
- Fire: store `reset_potential`, assert spike for that index. No fire: store d.
- Negative potentials decay but never fire.
- `RESET`, including mid-sweep: all potentials → 0, all shifts → 0, FSM → IDLE, index → 0, edge-detector register → 0, all outputs low.

## Timing
- Reset values: `busy`=0, `spike_valid`=0, `spike_addr`=0, `done`=0, `wr_ready`=1.
- A write presented in IDLE at edge k is visible on `rd_potential` after edge k.
- Let the clear rising edge be sampled at edge t:
  - `busy` is high cycles t+1 … t+N+1, where N=NEURONS.
  - Neuron i is processed in cycle t+1+i; its storage updates at the edge ending that cycle.
  - A spike for neuron i is registered: `spike_valid`/`spike_addr` are high during cycle t+2+i.
  - `done` is high during cycle t+N+1 (state DONE), coincident with the spike of neuron N−1 if it fires.
  - `wr_ready` returns high in cycle t+N+2.
- Sweep latency is N+1 cycles. The minimum spacing between effective clear edges is N+2 cycles.

## Test plan
- Reset mid-sweep: init neuron 3 = 0x41200000 (10.0), start sweep, assert `RESET` at cycle t+2. Required: `busy`=0 immediately, `rd_potential`(3)=0, no spikes, next clear edge runs a full sweep.
- Basic decay: N=4, neuron 0 = 10.0 with shift 1, threshold 0x42C80000 (100.0), clear pulse. Required: neuron 0 reads 0x40A00000 (5.0), no `spike_valid`, `done` exactly in cycle t+5.
- Fire/reset: neuron 2 = 0x41000000 (8.0), shift 1, threshold 0x40800000 (4.0), reset_potential 0. Required: `spike_valid` with `spike_addr`=2 in cycle t+4, neuron 2 reads 0.
- Boundaries:
  - neuron 1 = 0x00800000 (smallest normal), shift 3 → 0.
  - neuron 0 = 0xC1200000 (−10.0), shift 2 → 0xC0200000 (−2.5), no spike.
  - neuron 3 = 0x7F800000 (+Inf) stays unchanged and fires.
- Write arbitration: in IDLE, same cycle init(1, 1.0) and update(1, 2.0) → 0x3F800000 stored. During busy, update(1, 7.0) dropped and `wr_ready`=0.
- Clear handling: hold `clear` high for 3N cycles → exactly one sweep. A second rising edge during SCAN → ignored; exactly one `done` pulse.
